ram_dp_clr: RTL and testbench
=============================

Name: ram_dp_clr

Overview:
Parametrised simple-dual-port synchronous RAM. Successor to the CPU's 8-bit data RAM. Adds independent same-cycle read and write, a selectable read-during-write policy, optional output register, per-read valid strobe, and a clear engine that zeroes the array after reset or on request. Sits between the CPU datapath and block RAM; exports registered debug taps of the low addresses for the display/debug path.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words
NUM_TAPS, 5, number of debug tap words (addresses 0..NUM_TAPS-1), 1 <= NUM_TAPS <= DEPTH
RDW_MODE, 0, same-address read/write collision: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 0 = read latency 1, 1 = read latency 2
CLEAR_ON_RESET, 1, 1 = run clear engine automatically after reset release

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  asynchronous active-low reset
clr_req  in  1  single-cycle request to zero the whole array
busy  out  1  high while clear engine runs
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  read data, held between reads
rd_valid  out  1  one-cycle pulse when rd_data updates from an accepted read
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
taps  out  NUM_TAPS*DATA_WIDTH  shadow copies of words 0..NUM_TAPS-1; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (n_rst). While n_rst=0: rd_data=0, rd_valid=0, taps=0, output pipeline cleared. FSM goes to CLEAR with clr_addr=0 if CLEAR_ON_RESET=1, else IDLE; busy follows the FSM state. Array contents are not reset by n_rst; only the clear engine zeroes them.
- FSM states: IDLE, CLEAR.
  - IDLE to CLEAR when clr_req=1; busy rises the next cycle.
  - In CLEAR, each cycle writes 0 to clr_addr and increments it. After the write to DEPTH-1, the FSM returns to IDLE.
  - busy is high for exactly DEPTH cycles per clear.
- clr_req while in CLEAR: ignored, no restart.
- Reset asserted mid-clear: FSM restarts per the reset rule; a partial clear is abandoned.
- While busy=1: rd_en and wr_en are ignored, no rd_valid is produced, and the array is written only by the engine. taps all go 0 on the first CLEAR cycle.
- A read accepted in the cycle clr_req is sampled completes normally.
- Read: accepted when rd_en=1 and busy=0.
  - OUT_REG=0: rd_data and rd_valid update at edge t+1.
  - OUT_REG=1: they update at t+2.
  - rd_valid is high exactly one cycle per accepted read. Back-to-back reads give back-to-back valids, full throughput.
  - Without an accepted read, rd_data holds its last value.
- Write: accepted when wr_en=1 and busy=0; the array updates at the edge.
- Simultaneous read and write are both accepted, with no priority (unlike the previous RAM).
  - Same address, RDW_MODE=0: read returns the pre-write word.
  - Same address, RDW_MODE=1: read returns wr_data.
  - Different addresses: independent.
- taps: registered shadow registers, so the array stays BRAM-inferable.
  - An accepted write to addr < NUM_TAPS updates tap[addr] at the same edge as the array, so the tap equals memory from the following cycle.
  - With CLEAR_ON_RESET=0, taps read 0 until written while array contents are undefined.
- Widths: DEPTH is an exact power of two, so no out-of-range addresses exist. clr_addr is ADDR_WIDTH+1 bits internally to detect terminal count without wrap.

Decomposition:
- Shared package ram_pkg:
  - rdw_mode_t enum (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1)
  - ram_state_t enum (IDLE, CLEAR)
  - DATA_WIDTH/BUS_WIDTH defaults aligned with params.svh
- One sub-module, ram_clear_ctrl. It holds the FSM and clr_addr counter and outputs busy, clr_we and clr_addr.
- The top holds the array, write mux (engine vs port), read pipeline, RDW bypass and taps.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> busy high exactly 16 cycles; then reads of all 16 addresses return 0; taps=0.
- Write 0xA5 to addr 3 at t, rd_en addr 3 at t+1, OUT_REG=0 -> rd_data=0xA5 and rd_valid=1 at t+2 only; tap[3]=0xA5 from t+1.
- Same-cycle write 0x3C / read addr 7 holding 0x11 -> RDW_MODE=0 returns 0x11, RDW_MODE=1 returns 0x3C. Repeat with OUT_REG=1 to check 2-cycle latency.
- Back-to-back reads of addrs 0,1,2 over 3 cycles -> 3 consecutive rd_valid pulses with matching data; rd_data holds after the last read.
- clr_req mid-traffic, with writes and reads issued during busy -> none take effect, no rd_valid; after busy falls, all words and taps read 0. A second clr_req during busy does not extend the busy pulse.
- n_rst pulsed low halfway through a clear -> rd_data=0, rd_valid=0 immediately; the clear restarts at addr 0 and busy lasts a full DEPTH cycles after release.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and defaults for the dual-port data RAM and its clear engine.
package ram_pkg;

  // Default word and address-bus widths for the CPU data RAM.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BUS_WIDTH  = 8;
  localparam int DEF_NUM_TAPS   = 5;

  // Same-address read/write collision policy.
  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_t;

  // Clear engine states.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram_dp_clr_if.sv
// Port bundle of the dual-port RAM: clear request, read port, write port, debug taps.
interface ram_dp_clr_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_BUS_WIDTH,
  parameter int NUM_TAPS   = DEF_NUM_TAPS
);
  logic                           clr_req;
  logic                           busy;
  logic                           rd_en;
  logic [ADDR_WIDTH-1:0]          rd_addr;
  logic [DATA_WIDTH-1:0]          rd_data;
  logic                           rd_valid;
  logic                           wr_en;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic [NUM_TAPS*DATA_WIDTH-1:0] taps;

  // Requester side (CPU datapath).
  modport master (
    output clr_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  busy, rd_data, rd_valid, taps
  );

  // RAM side.
  modport slave (
    input  clr_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output busy, rd_data, rd_valid, taps
  );
endinterface

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks every address once, writing zero, after reset or on request.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_BUS_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic                  clr_start,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  localparam ram_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  // One extra bit so the terminal count shows up as a carry instead of a wrap.
  localparam logic [ADDR_WIDTH:0] ADDR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  ram_state_t            state_reg, state_next;
  logic [ADDR_WIDTH:0]   addr_reg, addr_next;

  // State and address counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= RESET_STATE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  // Next-state logic; requests during CLEAR are ignored.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    clr_we     = 1'b0;
    clr_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          addr_next  = '0;
          clr_start  = 1'b1;
        end
      end
      CLEAR: begin
        clr_we    = 1'b1;
        addr_next = addr_reg + ADDR_ONE;
        if (addr_next[ADDR_WIDTH]) begin
          state_next = IDLE;
          addr_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        addr_next  = '0;
      end
    endcase
  end

  assign busy     = (state_reg == CLEAR);
  assign clr_addr = addr_reg[ADDR_WIDTH-1:0];
endmodule

// File: rtl/ram_dp_clr.sv
// Simple-dual-port data RAM with read-during-write policy, optional output
// register, read-valid strobe, clear engine and registered debug taps.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_BUS_WIDTH,
  parameter int NUM_TAPS       = DEF_NUM_TAPS,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic        clk,
  input logic        n_rst,
  ram_dp_clr_if.slave bus
);
  localparam int DEPTH       = 2 ** ADDR_WIDTH;
  localparam bit WRITE_FIRST = (RDW_MODE == int'(RDW_WRITE_FIRST));

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy, clr_we, clr_start;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  rd_acc, wr_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  v1_reg;
  logic                  byp_sel_reg;
  logic [DATA_WIDTH-1:0] byp_data_reg;
  logic [DATA_WIDTH-1:0] rd_word;

  ram_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr_req   (bus.clr_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_start (clr_start),
    .clr_addr  (clr_addr)
  );

  assign bus.busy = busy;
  // Both ports are locked out while the engine owns the array.
  assign rd_acc    = bus.rd_en & ~busy;
  assign wr_acc    = bus.wr_en & ~busy;
  assign mem_we    = clr_we | wr_acc;
  assign mem_waddr = clr_we ? clr_addr : bus.wr_addr;
  assign mem_wdata = clr_we ? '0 : bus.wr_data;

  // Block RAM body: write port plus enabled, registered read (old data on collision).
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_acc) mem_q <= mem[bus.rd_addr];
  end

  // First read stage: valid strobe and write-first bypass capture.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1_reg       <= 1'b0;
      byp_sel_reg  <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      v1_reg <= rd_acc;
      if (rd_acc) begin
        byp_sel_reg  <= WRITE_FIRST && wr_acc && (bus.wr_addr == bus.rd_addr);
        byp_data_reg <= bus.wr_data;
      end
    end
  end

  assign rd_word = byp_sel_reg ? byp_data_reg : mem_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd_data_reg;
      logic                  rd_valid_reg;

      // Second read stage: holds the last word between reads.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= v1_reg;
          if (v1_reg) rd_data_reg <= rd_word;
        end
      end

      assign bus.rd_data  = rd_data_reg;
      assign bus.rd_valid = rd_valid_reg;
    end else begin : g_no_out_reg
      logic data_ok_reg;

      // The BRAM output latch has no reset, so mask it until a read has landed.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) data_ok_reg <= 1'b0;
        else if (rd_acc) data_ok_reg <= 1'b1;
      end

      assign bus.rd_data  = data_ok_reg ? rd_word : '0;
      assign bus.rd_valid = v1_reg;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      logic [DATA_WIDTH-1:0] tap_reg;

      // Shadow of word gi; zeroed as soon as a clear starts.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) tap_reg <= '0;
        else if (clr_start || busy) tap_reg <= '0;
        else if (wr_acc && (bus.wr_addr == ADDR_WIDTH'(gi))) tap_reg <= bus.wr_data;
      end

      assign bus.taps[gi*DATA_WIDTH +: DATA_WIDTH] = tap_reg;
    end
  endgenerate
endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: two instances (read-first/latency 1 and
// write-first/latency 2) driven with identical stimulus.
module tb_ram_dp_clr;
  logic       clk = 1'b0;
  logic       n_rst;
  logic       clr_req, rd_en, wr_en;
  logic [3:0] rd_addr, wr_addr;
  logic [7:0] wr_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] tap_model [5];
  logic [7:0] last0, last1;

  ram_dp_clr_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_TAPS(5)) bus0 ();
  ram_dp_clr_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_TAPS(5)) bus1 ();

  assign bus0.clr_req = clr_req;
  assign bus0.rd_en   = rd_en;
  assign bus0.rd_addr = rd_addr;
  assign bus0.wr_en   = wr_en;
  assign bus0.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;
  assign bus1.clr_req = clr_req;
  assign bus1.rd_en   = rd_en;
  assign bus1.rd_addr = rd_addr;
  assign bus1.wr_en   = wr_en;
  assign bus1.wr_addr = wr_addr;
  assign bus1.wr_data = wr_data;

  ram_dp_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_TAPS(5), .RDW_MODE(0),
               .OUT_REG(0), .CLEAR_ON_RESET(1))
    dut0 (.clk(clk), .n_rst(n_rst), .bus(bus0));
  ram_dp_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_TAPS(5), .RDW_MODE(1),
               .OUT_REG(1), .CLEAR_ON_RESET(1))
    dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1));

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic [7:0] exp0;  // read-first result
    logic [7:0] exp1;  // write-first result
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_taps(input string nm);
    logic [39:0] e;
    for (int i = 0; i < 5; i++) e[i*8 +: 8] = tap_model[i];
    chk({nm, "_taps0"}, 64'(bus0.taps), 64'(e));
    chk({nm, "_taps1"}, 64'(bus1.taps), 64'(e));
  endtask

  // One transaction cycle, then check both latencies.
  task automatic do_op(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic re, input logic [3:0] ra,
                       input logic [7:0] e0, input logic [7:0] e1, input string nm);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    if (we && wa < 4'd5) tap_model[wa] = wd;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    if (re) last0 = e0;
    chk({nm, "_valid0_t1"}, 64'(bus0.rd_valid), 64'(re));
    chk({nm, "_data0_t1"},  64'(bus0.rd_data),  64'(last0));
    chk({nm, "_valid1_t1"}, 64'(bus1.rd_valid), 64'(0));
    chk({nm, "_data1_t1"},  64'(bus1.rd_data),  64'(last1));
    check_taps(nm);
    step();
    if (re) last1 = e1;
    chk({nm, "_valid0_t2"}, 64'(bus0.rd_valid), 64'(0));
    chk({nm, "_data0_t2"},  64'(bus0.rd_data),  64'(last0));
    chk({nm, "_valid1_t2"}, 64'(bus1.rd_valid), 64'(re));
    chk({nm, "_data1_t2"},  64'(bus1.rd_data),  64'(last1));
  endtask

  // Counts sampled busy cycles starting at the current sample point.
  task automatic count_busy(input string nm);
    int cnt = 0;
    while (bus0.busy && cnt < 100) begin
      cnt++;
      step();
    end
    chk({nm, "_cycles"}, 64'(cnt), 64'(16));
    chk({nm, "_busy1_done"}, 64'(bus1.busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sa_v0, sa_v1;
    logic [7:0] sa_d0 [6];
    logic [7:0] sa_d1 [6];
    int cnt;

    clr_req = 0; rd_en = 0; wr_en = 0; rd_addr = 0; wr_addr = 0; wr_data = 0;
    for (int i = 0; i < 5; i++) tap_model[i] = 8'h00;
    last0 = 8'h00; last1 = 8'h00;

    vecs[0]  = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  8'hA5, 8'hA5};
    vecs[2]  = '{1'b1, 4'd7,  8'h11, 1'b0, 4'd0,  8'h00, 8'h00};
    vecs[3]  = '{1'b1, 4'd7,  8'h3C, 1'b1, 4'd7,  8'h11, 8'h3C};
    vecs[4]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  8'h3C, 8'h3C};
    vecs[5]  = '{1'b1, 4'd1,  8'h5A, 1'b1, 4'd3,  8'hA5, 8'hA5};
    vecs[6]  = '{1'b1, 4'd4,  8'hF0, 1'b1, 4'd4,  8'h00, 8'hF0};
    vecs[7]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd4,  8'hF0, 8'hF0};
    vecs[8]  = '{1'b1, 4'd15, 8'h77, 1'b1, 4'd1,  8'h5A, 8'h5A};
    vecs[9]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 8'h77, 8'h77};
    vecs[10] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 8'h00};
    vecs[11] = '{1'b1, 4'd0,  8'h99, 1'b1, 4'd0,  8'h00, 8'h99};

    // Reset state.
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    step(); step();
    chk("rst_data0",  64'(bus0.rd_data),  64'(0));
    chk("rst_data1",  64'(bus1.rd_data),  64'(0));
    chk("rst_valid0", 64'(bus0.rd_valid), 64'(0));
    chk("rst_valid1", 64'(bus1.rd_valid), 64'(0));
    chk("rst_busy0",  64'(bus0.busy),     64'(1));
    check_taps("rst");

    // Auto clear after reset release, then the whole array reads zero.
    n_rst = 1'b1;
    count_busy("rst_clear");
    for (int a = 0; a < 16; a++) do_op(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 8'h00, 8'h00, $sformatf("clr_rd%0d", a));

    // Directed vectors.
    for (int i = 0; i < 12; i++)
      do_op(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra,
            vecs[i].exp0, vecs[i].exp1, $sformatf("vec%0d", i));

    // Write at t, back-to-back reads at t+1..t+3.
    sa_v0 = 8'b00001110;  // bit k: valid expected after edge k
    sa_v1 = 8'b00011100;
    sa_d0 = '{8'h00, 8'h99, 8'h5A, 8'h21, 8'h21, 8'h21};
    sa_d1 = '{8'h99, 8'h99, 8'h99, 8'h5A, 8'h21, 8'h21};
    for (int k = 0; k < 6; k++) begin
      wr_en = (k == 0); wr_addr = 4'd2; wr_data = 8'h21;
      rd_en = (k >= 1 && k <= 3); rd_addr = 4'(k - 1);
      if (k == 0) tap_model[2] = 8'h21;
      step();
      chk($sformatf("b2b_valid0_%0d", k), 64'(bus0.rd_valid), 64'(sa_v0[k]));
      chk($sformatf("b2b_data0_%0d", k),  64'(bus0.rd_data),  64'(sa_d0[k]));
      chk($sformatf("b2b_valid1_%0d", k), 64'(bus1.rd_valid), 64'(sa_v1[k]));
      chk($sformatf("b2b_data1_%0d", k),  64'(bus1.rd_data),  64'(sa_d1[k]));
      if (k == 0) check_taps("b2b");
    end
    wr_en = 0; rd_en = 0;
    last0 = 8'h21; last1 = 8'h21;

    // Clear request with a read in the same cycle, then traffic during busy.
    clr_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd3;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 5; i++) tap_model[i] = 8'h00;
    last0 = 8'hA5;
    chk("clr_busy_rise", 64'(bus0.busy),     64'(1));
    chk("clr_rd_valid0", 64'(bus0.rd_valid), 64'(1));
    chk("clr_rd_data0",  64'(bus0.rd_data),  64'(8'hA5));
    chk("clr_rd_valid1", 64'(bus1.rd_valid), 64'(0));
    check_taps("clr_first");
    last1 = 8'hA5;
    cnt = 0;
    while (bus0.busy && cnt < 100) begin
      clr_req = (cnt == 3);
      rd_en = 1'b1; rd_addr = 4'd3;
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hEE;
      step();
      chk($sformatf("busy_valid0_%0d", cnt), 64'(bus0.rd_valid), 64'(0));
      chk($sformatf("busy_data0_%0d", cnt),  64'(bus0.rd_data),  64'(last0));
      chk($sformatf("busy_valid1_%0d", cnt), 64'(bus1.rd_valid), 64'(cnt == 0));
      chk($sformatf("busy_data1_%0d", cnt),  64'(bus1.rd_data),  64'(last1));
      cnt++;
    end
    clr_req = 0; rd_en = 0; wr_en = 0;
    chk("clr_busy_cycles", 64'(cnt), 64'(16));
    check_taps("clr_done");
    for (int a = 0; a < 16; a++) do_op(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 8'h00, 8'h00, $sformatf("clr2_rd%0d", a));

    // Reset in the middle of a clear.
    do_op(1'b1, 4'd6, 8'h42, 1'b0, 4'd0, 8'h00, 8'h00, "mid_wr");
    do_op(1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 8'h42, 8'h42, "mid_rd");
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    n_rst = 1'b0;
    #1;
    last0 = 8'h00; last1 = 8'h00;
    chk("midrst_data0",  64'(bus0.rd_data),  64'(0));
    chk("midrst_data1",  64'(bus1.rd_data),  64'(0));
    chk("midrst_valid0", 64'(bus0.rd_valid), 64'(0));
    chk("midrst_valid1", 64'(bus1.rd_valid), 64'(0));
    chk("midrst_busy",   64'(bus0.busy),     64'(1));
    check_taps("midrst");
    step(); step();
    n_rst = 1'b1;
    count_busy("midrst_clear");
    do_op(1'b0, 4'd0, 8'h00, 1'b1, 4'd6,  8'h00, 8'h00, "post_rd6");
    do_op(1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 8'h00, 8'h00, "post_rd15");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
